// File: rtl/pixel_frame_tx_ctrl.sv
// rtl/pixel_frame_tx_ctrl.sv - frame sequencer feeding BRAM pixels to the UART pixel sender
// Reads one frame (optionally led by a marker word) and hands each word over a valid/ready link.
module pixel_frame_tx_ctrl #(
  parameter int                 IMAGE_SIZE = 100,
  parameter int                 ADDR_W     = 17,
  parameter int                 PIXEL_W    = 12,
  parameter bit                 HEADER_EN  = 1'b1,
  parameter logic [PIXEL_W-1:0] SOF_WORD   = PIXEL_W'(12'hFFF)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  output logic [ADDR_W-1:0]  rd_addr,
  input  logic [PIXEL_W-1:0] rd_data,
  output logic [PIXEL_W-1:0] pixel,
  output logic               valid_out,
  input  logic               ready_in,
  output logic               busy,
  output logic               done,
  output logic [7:0]         frame_count
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_HEADER  = 3'd1;
  localparam logic [2:0] S_FETCH   = 3'd2;
  localparam logic [2:0] S_LATCH   = 3'd3;
  localparam logic [2:0] S_PRESENT = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(IMAGE_SIZE - 1);

  logic [2:0]         state_q, state_d;
  logic [ADDR_W-1:0]  idx_q, idx_d;
  logic [PIXEL_W-1:0] pixel_q, pixel_d;
  logic [7:0]         count_q, count_d;
  logic               valid_q, busy_q, done_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    pixel_d = pixel_q;
    count_d = count_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          idx_d = '0;
          if (HEADER_EN) begin
            state_d = S_HEADER;
            pixel_d = SOF_WORD;
          end else begin
            state_d = S_FETCH;
          end
        end
      end
      S_HEADER: begin
        if (ready_in) state_d = S_FETCH;
      end
      S_FETCH: state_d = S_LATCH;
      S_LATCH: begin
        pixel_d = rd_data;
        state_d = S_PRESENT;
      end
      S_PRESENT: begin
        if (ready_in) begin
          if (idx_q == LAST_IDX) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + ADDR_W'(1);
            state_d = S_FETCH;
          end
        end
      end
      S_DONE: begin
        count_d = count_q + 8'd1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // abort overrides everything, including a same-cycle handshake and a start in IDLE
    if (abort) begin
      state_d = S_IDLE;
      idx_d   = idx_q;
      pixel_d = pixel_q;
      count_d = count_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      pixel_q <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pixel_q <= pixel_d;
      count_q <= count_d;
      valid_q <= (state_d == S_HEADER) || (state_d == S_PRESENT);
      busy_q  <= (state_d != S_IDLE);
      done_q  <= (state_d == S_DONE);
    end
  end

  // the index itself drives the BRAM; it only moves on leaving PRESENT, so it holds under backpressure
  assign rd_addr     = idx_q;
  assign pixel       = pixel_q;
  assign valid_out   = valid_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign frame_count = count_q;

endmodule

// File: tb/tb_pixel_frame_tx_ctrl.sv
// tb/tb_pixel_frame_tx_ctrl.sv - directed and randomized checks of pixel_frame_tx_ctrl
// Instance a: 4-pixel frame with header; instance b: 1-pixel frame without header.
module tb_pixel_frame_tx_ctrl;
  localparam int          N_A = 4;
  localparam logic [11:0] SOF = 12'hFFF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, start_a, abort_a, ready_a, valid_a, busy_a, done_a;
  logic [16:0] rd_addr_a;
  logic [11:0] rd_data_a, pixel_a;
  logic [7:0]  fc_a;
  logic        rst_b, start_b, abort_b, ready_b, valid_b, busy_b, done_b;
  logic [16:0] rd_addr_b;
  logic [11:0] rd_data_b, pixel_b;
  logic [7:0]  fc_b;

  pixel_frame_tx_ctrl #(.IMAGE_SIZE(N_A), .HEADER_EN(1'b1)) dut_a (
    .clk(clk), .rst(rst_a), .start(start_a), .abort(abort_a),
    .rd_addr(rd_addr_a), .rd_data(rd_data_a), .pixel(pixel_a),
    .valid_out(valid_a), .ready_in(ready_a), .busy(busy_a),
    .done(done_a), .frame_count(fc_a)
  );

  pixel_frame_tx_ctrl #(.IMAGE_SIZE(1), .HEADER_EN(1'b0)) dut_b (
    .clk(clk), .rst(rst_b), .start(start_b), .abort(abort_b),
    .rd_addr(rd_addr_b), .rd_data(rd_data_b), .pixel(pixel_b),
    .valid_out(valid_b), .ready_in(ready_b), .busy(busy_b),
    .done(done_b), .frame_count(fc_b)
  );

  logic [11:0] mem_a [N_A];
  logic [11:0] mem_b;
  always @(posedge clk) rd_data_a <= mem_a[rd_addr_a[1:0]];
  always @(posedge clk) rd_data_b <= mem_b;

  logic [11:0] rx_a [$];
  logic [11:0] exp_q [$];
  int done_cnt_a = 0;
  int done_cnt_b = 0;
  bit oob = 1'b0;

  // accepted words: a handshake at an edge that also sees rst or abort is discarded
  always @(posedge clk) begin
    if (!rst_a && !abort_a && valid_a && ready_a) rx_a.push_back(pixel_a);
    if (done_a) done_cnt_a <= done_cnt_a + 1;
    if (done_b) done_cnt_b <= done_cnt_b + 1;
    if (rd_addr_a >= 17'(N_A) || rd_addr_b != 17'd0) oob <= 1'b1;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done_a();
    int n = 0;
    while (done_a !== 1'b1 && n < 400) begin
      tick();
      n++;
    end
  endtask

  // reference: a frame is the marker followed by every buffer word in address order
  task automatic build_frame();
    exp_q.delete();
    exp_q.push_back(SOF);
    for (int i = 0; i < N_A; i++) exp_q.push_back(mem_a[i]);
  endtask

  task automatic cmp_rx(input string tag);
    chk({tag, "_len"}, 32'(rx_a.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < rx_a.size(); i++)
      chk({tag, "_word"}, 32'(rx_a[i]), 32'(exp_q[i]));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, dc0, base;
    logic [7:0] fc0;
    bit bad;
    int lat_bad, pix_bad, done_bad, fc_bad;

    rst_a = 1'b1; start_a = 1'b0; abort_a = 1'b0; ready_a = 1'b0;
    rst_b = 1'b1; start_b = 1'b0; abort_b = 1'b0; ready_b = 1'b0;
    mem_b = 12'h000;
    for (int i = 0; i < N_A; i++) mem_a[i] = 12'h000;
    repeat (3) tick();

    chk("rst_valid", 32'(valid_a), 32'd0);
    chk("rst_pixel", 32'(pixel_a), 32'd0);
    chk("rst_addr", 32'(rd_addr_a), 32'd0);
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_done", 32'(done_a), 32'd0);
    chk("rst_fc", 32'(fc_a), 32'd0);
    chk("rst_b_valid", 32'(valid_b), 32'd0);
    rst_a = 1'b0; rst_b = 1'b0;
    tick();

    // directed frame, constant ready, start also pulsed in the DONE cycle
    mem_a[0] = 12'h00F; mem_a[1] = 12'h0F0; mem_a[2] = 12'hF00; mem_a[3] = 12'hABC;
    build_frame();
    rx_a.delete();
    ready_a = 1'b1;
    start_a = 1'b1; tick(); start_a = 1'b0;
    chk("t1_hdr_latency", 32'(valid_a), 32'd1);
    chk("t1_hdr_word", 32'(pixel_a), 32'(SOF));
    chk("t1_busy", 32'(busy_a), 32'd1);
    wait_done_a();
    chk("t1_done_seen", 32'(done_a), 32'd1);
    chk("t1_done_busy", 32'(busy_a), 32'd1);
    start_a = 1'b1; tick(); start_a = 1'b0;
    chk("t1_idle_busy", 32'(busy_a), 32'd0);
    chk("t1_fc", 32'(fc_a), 32'd1);
    repeat (5) tick();
    chk("t1_start_in_done_ignored", 32'(busy_a), 32'd0);
    cmp_rx("t1");
    chk("t1_done_cnt", 32'(done_cnt_a), 32'd1);

    // random contents, random ready, spurious starts while busy, back-to-back frames
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < N_A; i++) mem_a[i] = 12'($urandom);
      build_frame();
      rx_a.delete();
      dc0 = done_cnt_a;
      start_a = 1'b1; tick(); start_a = 1'b0;
      chk("rnd_hdr_latency", 32'(valid_a), 32'd1);
      n = 0;
      while (done_a !== 1'b1 && n < 400) begin
        ready_a = 1'($urandom_range(0, 1));
        start_a = ($urandom_range(0, 3) == 0);
        tick();
        n++;
      end
      start_a = 1'b0; ready_a = 1'b1;
      chk("rnd_done_seen", 32'(done_a), 32'd1);
      tick();
      chk("rnd_idle", 32'(busy_a), 32'd0);
      cmp_rx("rnd");
      chk("rnd_done_cnt", 32'(done_cnt_a), 32'(dc0 + 1));
    end
    chk("rnd_fc", 32'(fc_a), 32'd5);

    // backpressure at index 2
    for (int i = 0; i < N_A; i++) mem_a[i] = 12'($urandom);
    mem_a[2] = 12'hF00;
    build_frame();
    rx_a.delete();
    ready_a = 1'b0;
    start_a = 1'b1; tick(); start_a = 1'b0;
    n = 0;
    while (!(valid_a === 1'b1 && rd_addr_a == 17'd2) && n < 60) begin
      ready_a = valid_a;
      tick();
      n++;
    end
    ready_a = 1'b0;
    chk("bp_reached", 32'(valid_a && rd_addr_a == 17'd2), 32'd1);
    base = rx_a.size();
    bad = 1'b0;
    repeat (20) begin
      tick();
      if (valid_a !== 1'b1 || pixel_a !== 12'hF00 || rd_addr_a !== 17'd2) bad = 1'b1;
    end
    chk("bp_stable", 32'(bad), 32'd0);
    chk("bp_no_xfer", 32'(rx_a.size()), 32'(base));
    ready_a = 1'b1; tick(); ready_a = 1'b0;
    chk("bp_one_xfer", 32'(rx_a.size()), 32'(base + 1));
    chk("bp_next_addr", 32'(rd_addr_a), 32'd3);
    repeat (4) tick();
    chk("bp_still_one", 32'(rx_a.size()), 32'(base + 1));
    ready_a = 1'b1;
    wait_done_a();
    chk("bp_done_seen", 32'(done_a), 32'd1);
    tick();
    cmp_rx("bp");
    chk("bp_fc", 32'(fc_a), 32'd6);

    // abort after two accepted pixels, then a clean restart
    rx_a.delete();
    dc0 = done_cnt_a;
    fc0 = fc_a;
    start_a = 1'b1; tick(); start_a = 1'b0;
    n = 0;
    while (rx_a.size() < 3 && n < 60) begin
      tick();
      n++;
    end
    abort_a = 1'b1; tick(); abort_a = 1'b0;
    chk("ab_valid", 32'(valid_a), 32'd0);
    chk("ab_busy", 32'(busy_a), 32'd0);
    repeat (10) tick();
    chk("ab_words", 32'(rx_a.size()), 32'd3);
    chk("ab_no_done", 32'(done_cnt_a), 32'(dc0));
    chk("ab_fc", 32'(fc_a), 32'(fc0));
    rx_a.delete();
    start_a = 1'b1; tick(); start_a = 1'b0;
    wait_done_a();
    tick();
    cmp_rx("ab_restart");
    chk("ab_restart_fc", 32'(fc_a), 32'(fc0 + 8'd1));

    // abort beats a same-cycle header handshake
    rx_a.delete();
    ready_a = 1'b0;
    start_a = 1'b1; tick(); start_a = 1'b0;
    ready_a = 1'b1; abort_a = 1'b1; tick(); abort_a = 1'b0;
    repeat (4) tick();
    chk("ab_hs_busy", 32'(busy_a), 32'd0);
    chk("ab_hs_words", 32'(rx_a.size()), 32'd0);

    // start together with abort in IDLE
    start_a = 1'b1; abort_a = 1'b1; tick(); start_a = 1'b0; abort_a = 1'b0;
    bad = 1'b0;
    repeat (6) begin
      if (valid_a !== 1'b0 || busy_a !== 1'b0) bad = 1'b1;
      tick();
    end
    chk("start_abort_idle", 32'(bad), 32'd0);

    // reset while a pixel is presented
    ready_a = 1'b0;
    start_a = 1'b1; tick(); start_a = 1'b0;
    ready_a = 1'b1; tick(); ready_a = 1'b0;
    tick(); tick();
    ready_a = 1'b1; tick(); ready_a = 1'b0;
    tick(); tick(); tick();
    chk("rst_pre_valid", 32'(valid_a), 32'd1);
    chk("rst_pre_addr", 32'(rd_addr_a), 32'd1);
    base = rx_a.size();
    ready_a = 1'b1; rst_a = 1'b1; tick(); rst_a = 1'b0; ready_a = 1'b0;
    chk("rst_mid_valid", 32'(valid_a), 32'd0);
    chk("rst_mid_pixel", 32'(pixel_a), 32'd0);
    chk("rst_mid_addr", 32'(rd_addr_a), 32'd0);
    chk("rst_mid_busy", 32'(busy_a), 32'd0);
    chk("rst_mid_fc", 32'(fc_a), 32'd0);
    chk("rst_mid_no_xfer", 32'(rx_a.size()), 32'(base));

    // 256 single-pixel frames without header
    ready_b = 1'b1;
    lat_bad = 0; pix_bad = 0; done_bad = 0; fc_bad = 0;
    for (int f = 1; f <= 256; f++) begin
      mem_b = 12'($urandom);
      start_b = 1'b1; tick(); start_b = 1'b0;
      n = 1;
      while (valid_b !== 1'b1 && n < 10) begin
        tick();
        n++;
      end
      if (n != 3) lat_bad++;
      if (pixel_b !== mem_b) pix_bad++;
      tick();
      if (done_b !== 1'b1) done_bad++;
      tick();
      if (fc_b !== 8'(f)) fc_bad++;
      if (f == 255) chk("b_fc_255", 32'(fc_b), 32'd255);
    end
    chk("b_latency", 32'(lat_bad), 32'd0);
    chk("b_pixel", 32'(pix_bad), 32'd0);
    chk("b_done", 32'(done_bad), 32'd0);
    chk("b_fc_seq", 32'(fc_bad), 32'd0);
    chk("b_fc_wrap", 32'(fc_b), 32'd0);
    chk("b_done_cnt", 32'(done_cnt_b), 32'd256);
    chk("addr_in_range", 32'(oob), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
